// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator with registered, mutually aligned outputs.
// Optional per-line interrupt is enabled by defining VGA_TIMING_LINE_IRQ_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23,
  parameter bit H_SYNC_POL  = 1'b1,
  parameter bit V_SYNC_POL  = 1'b1,
  parameter int COORD_W     = 16,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   i_pix_clk,
  input  logic                   i_reset_n,
  input  logic                   i_pix_en,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [COORD_W-1:0]     i_irq_line,
  output logic                   o_line_irq,
`endif
  output logic [COORD_W-1:0]     o_horz_coord,
  output logic [COORD_W-1:0]     o_vert_coord,
  output logic                   o_in_active_area,
  output logic                   o_horz_blank,
  output logic                   o_vert_blank,
  output logic                   o_horz_sync,
  output logic                   o_vert_sync,
  output logic                   o_line_start,
  output logic                   o_frame_start,
  output logic [FRAME_CNT_W-1:0] o_frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (((H_TOTAL >> COORD_W) != 0) || ((V_TOTAL >> COORD_W) != 0)) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in COORD_W bits");
  end

  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FRAME_CNT_W-1:0] FC_ONE = FRAME_CNT_W'(1);

  logic [COORD_W-1:0]     h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0]     v_cnt_q, v_cnt_d;
  logic [COORD_W-1:0]     horz_coord_q, vert_coord_q;
  logic                   active_q, active_d;
  logic                   hblank_q, hblank_d;
  logic                   vblank_q, vblank_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   line_start_q, frame_start_q;
  logic                   h_zero, v_zero;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  // Suppresses the count on the very first (0,0) after reset.
  logic                   started_q;

  always_comb begin
    h_cnt_d  = h_cnt_q + C_ONE;
    v_cnt_d  = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + C_ONE;
    end
    h_zero   = (h_cnt_q == '0);
    v_zero   = (v_cnt_q == '0);
    hblank_d = (h_cnt_q >= H_ACT);
    vblank_d = (v_cnt_q >= V_ACT);
    active_d = !hblank_d && !vblank_d;
    hsync_d  = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d  = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      horz_coord_q  <= '0;
      vert_coord_q  <= '0;
      active_q      <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      started_q     <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (i_pix_en) begin
        h_cnt_q       <= h_cnt_d;
        v_cnt_q       <= v_cnt_d;
        horz_coord_q  <= h_cnt_q;
        vert_coord_q  <= v_cnt_q;
        active_q      <= active_d;
        hblank_q      <= hblank_d;
        vblank_q      <= vblank_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        line_start_q  <= h_zero;
        frame_start_q <= h_zero && v_zero;
        if (h_zero && v_zero) begin
          if (started_q) frame_cnt_q <= frame_cnt_q + FC_ONE;
          started_q <= 1'b1;
        end
      end
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  logic line_irq_q;

  // v_cnt never reaches V_TOTAL, so an out-of-range line request simply never matches.
  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      line_irq_q <= 1'b0;
    end else begin
      line_irq_q <= i_pix_en && (h_cnt_q == H_ACT) && (v_cnt_q == i_irq_line);
    end
  end

  assign o_line_irq = line_irq_q;
`endif

  assign o_horz_coord     = horz_coord_q;
  assign o_vert_coord     = vert_coord_q;
  assign o_in_active_area = active_q;
  assign o_horz_blank     = hblank_q;
  assign o_vert_blank     = vblank_q;
  assign o_horz_sync      = hsync_q;
  assign o_vert_sync      = vsync_q;
  assign o_line_start     = line_start_q;
  assign o_frame_start    = frame_start_q;
  assign o_frame_count    = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small mode and the default mode driven side by side,
// checked every clock against a position-index model (index -> h, v, frame).
module tb_vga_timing_gen;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int n = 0;          // enabled edges seen since the last reset
  bit last_en = 1'b0;

  logic [CW-1:0] s_h, s_v, d_h, d_v;
  logic s_act, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs;
  logic d_act, d_hb, d_vb, d_hs, d_vs, d_ls, d_fs;
  logic [1:0] s_fc;
  logic [7:0] d_fc;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [CW-1:0] s_irq_line = 16'd2;
  logic [CW-1:0] d_irq_line = 16'd10;
  logic s_irq, d_irq;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .COORD_W(CW), .FRAME_CNT_W(2)
  ) u_small (
    .i_pix_clk(clk), .i_reset_n(rst_n), .i_pix_en(pix_en),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .i_irq_line(s_irq_line), .o_line_irq(s_irq),
`endif
    .o_horz_coord(s_h), .o_vert_coord(s_v), .o_in_active_area(s_act),
    .o_horz_blank(s_hb), .o_vert_blank(s_vb), .o_horz_sync(s_hs), .o_vert_sync(s_vs),
    .o_line_start(s_ls), .o_frame_start(s_fs), .o_frame_count(s_fc)
  );

  vga_timing_gen u_default (
    .i_pix_clk(clk), .i_reset_n(rst_n), .i_pix_en(pix_en),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .i_irq_line(d_irq_line), .o_line_irq(d_irq),
`endif
    .o_horz_coord(d_h), .o_vert_coord(d_v), .o_in_active_area(d_act),
    .o_horz_blank(d_hb), .o_vert_blank(d_vb), .o_horz_sync(d_hs), .o_vert_sync(d_vs),
    .o_line_start(d_ls), .o_frame_start(d_fs), .o_frame_count(d_fc)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (enabled edges %0d, t=%0t)", tag, obs, exp, n, $time);
    end
  endtask

  // Expected outputs derived from the enabled-edge index n: position n-1 in raster order.
  task automatic check_mode(input string m,
                            input int ha, input int hfp, input int hsw, input int hbp,
                            input int va, input int vfp, input int vsw, input int vbp,
                            input bit hpol, input bit vpol, input int fcw,
                            input int oh, input int ov, input bit oact, input bit ohb,
                            input bit ovb, input bit ohs, input bit ovs, input bit ols,
                            input bit ofs, input int ofc);
    int ht, vt, idx, h, v, fc;
    bit act, hb, vb, hs, vs, ls, fs;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (n == 0) begin
      h = 0; v = 0; act = 0; hb = 0; vb = 0; hs = !hpol; vs = !vpol; ls = 0; fs = 0; fc = 0;
    end else begin
      idx = n - 1;
      h   = idx % ht;
      v   = (idx / ht) % vt;
      fc  = (idx / (ht * vt)) % (1 << fcw);
      hb  = (h >= ha);
      vb  = (v >= va);
      act = !hb && !vb;
      hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : !hpol;
      vs  = (v >= va + vfp && v < va + vfp + vsw) ? vpol : !vpol;
      ls  = last_en && (h == 0);
      fs  = last_en && (h == 0) && (v == 0);
    end
    chk({m, "_hcoord"}, oh, h);
    chk({m, "_vcoord"}, ov, v);
    chk({m, "_active"}, oact, act);
    chk({m, "_hblank"}, ohb, hb);
    chk({m, "_vblank"}, ovb, vb);
    chk({m, "_hsync"}, ohs, hs);
    chk({m, "_vsync"}, ovs, vs);
    chk({m, "_line_start"}, ols, ls);
    chk({m, "_frame_start"}, ofs, fs);
    chk({m, "_frame_count"}, ofc, fc);
  endtask

  task automatic check_all();
    check_mode("small", 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b1, 2,
               s_h, s_v, s_act, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs, s_fc);
    check_mode("dflt", 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 8,
               d_h, d_v, d_act, d_hb, d_vb, d_hs, d_vs, d_ls, d_fs, d_fc);
`ifdef VGA_TIMING_LINE_IRQ_EN
    begin
      bit s_exp, d_exp;
      s_exp = (n > 0) && last_en && ((n - 1) % 12 == 8) && (((n - 1) / 12) % 7 == int'(s_irq_line));
      d_exp = (n > 0) && last_en && ((n - 1) % 1056 == 800) && (((n - 1) / 1056) % 628 == int'(d_irq_line));
      chk("small_line_irq", s_irq, s_exp);
      chk("dflt_line_irq", d_irq, d_exp);
    end
`endif
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    #1;
    last_en = en && rst_n;
    if (last_en) n++;
    check_all();
  endtask

  localparam int TARGET_IDX = 45 * 1056 + 123;

  initial begin
    int guard;
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)));
    rst_n = 1'b1;

    // Continuous enable: small mode runs through many frames, default mode through three lines.
    for (int i = 0; i < 3 * 1056 + 50; i++) step(1'b1);

    // Enable every fourth clock.
    for (int i = 0; i < 84 * 4 * 2; i++) step(i % 4 == 3);

    // Random enable pattern.
    for (int i = 0; i < 2000; i++) step(1'($urandom_range(0, 1)));

`ifdef VGA_TIMING_LINE_IRQ_EN
    s_irq_line = 16'd9;
    d_irq_line = 16'd700;
    for (int i = 0; i < 400; i++) step(1'b1);
    s_irq_line = 16'd3;
    d_irq_line = 16'd10;
`endif

    // Run the default mode up to (123,45), then reset asynchronously mid-line.
    guard = 0;
    while (n < TARGET_IDX + 1 && guard < 60000) begin
      step(1'b1);
      guard++;
    end
    chk("dflt_reach_h123", d_h, 123);
    chk("dflt_reach_v45", d_v, 45);
    #2;
    rst_n = 1'b0;
    n = 0;
    last_en = 1'b0;
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step(1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < 1200; i++) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 800x600 controller.
- Produces pixel coordinates, blank and sync signals, line/frame start pulses and a frame counter for any VESA-style mode.
- All outputs are registered and mutually aligned. A pixel-enable strobe lets the block run from a faster system clock.
- Sits between the pixel clock domain and the pixel/colour generators, which consume the coordinates and the active flag.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- H_SYNC_POL, 1, asserted level of o_horz_sync (1 = active-high)
- V_SYNC_POL, 1, asserted level of o_vert_sync
- COORD_W, 16, width of the coordinate outputs
- FRAME_CNT_W, 8, width of the frame counter

Ports:
- i_pix_clk, in, 1, pixel/system clock, rising edge
- i_reset_n, in, 1, asynchronous active-low reset
- i_pix_en, in, 1, pixel advance strobe; tie to 1 for one pixel per clock
- o_horz_coord, out, COORD_W, current horizontal position
- o_vert_coord, out, COORD_W, current vertical position
- o_in_active_area, out, 1, position is inside the visible area
- o_horz_blank, out, 1, o_horz_coord >= H_ACTIVE
- o_vert_blank, out, 1, o_vert_coord >= V_ACTIVE
- o_horz_sync, out, 1, horizontal sync at H_SYNC_POL level
- o_vert_sync, out, 1, vertical sync at V_SYNC_POL level
- o_line_start, out, 1, one-clock pulse when the outputs load h = 0
- o_frame_start, out, 1, one-clock pulse when the outputs load (0,0)
- o_frame_count, out, FRAME_CNT_W, completed-frame counter

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP
  - Both totals must fit in COORD_W bits; the design must not elaborate otherwise.
- Internal counters h_cnt and v_cnt reset to 0.
- On each i_pix_en = 1 edge:
  - Outputs load the decode of (h_cnt, v_cnt).
  - The counters then advance: h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on the h wrap, and wraps V_TOTAL-1 -> 0.
- Latency: the first i_pix_en edge after reset shows (0,0) on the outputs. Each output value is held for exactly one enabled cycle.
- i_pix_en = 0: counters and all level outputs hold. o_line_start and o_frame_start return to 0.
- Decode, for output position (h, v):
  - active = h < H_ACTIVE and v < V_ACTIVE
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, spanning whole lines (changes only at h = 0)
  - When deasserted, each sync output drives the inverse of its polarity parameter.
- Pulses:
  - o_line_start is high for exactly one clock when h = 0 is loaded.
  - o_frame_start is high for exactly one clock when (0,0) is loaded; o_line_start is also high in that cycle.
- o_frame_count:
  - Increments by 1, modulo 2^FRAME_CNT_W, on the same edge that loads (0,0).
  - The first (0,0) after reset does not count; the value reads 0 during the first frame.
- Reset values, applied immediately on assertion, including mid-frame:
  - coordinates 0
  - o_in_active_area, blanks, o_line_start, o_frame_start = 0
  - syncs at their deasserted level
  - o_frame_count = 0
- After reset release, output resumes from (0,0) on the first enabled edge.
- Simultaneous events: the h and v wraps on the same edge are normal. The last pixel (H_TOTAL-1, V_TOTAL-1) is followed directly by (0,0) with o_frame_start.

Optional Feature:
- Macro: VGA_TIMING_LINE_IRQ_EN
- Defined:
  - Adds input i_irq_line [COORD_W] and output o_line_irq [1].
  - o_line_irq is a one-clock pulse on the enabled edge that loads h = H_ACTIVE (start of hblank) when v equals i_irq_line.
  - i_irq_line is sampled on that edge; a value >= V_TOTAL never fires.
  - Reset value of o_line_irq is 0.
- Undefined: neither port exists and there is no related logic.

Test Plan:
- Reset, then i_pix_en = 1 -> first edge gives (0,0) with active = 1 and both start pulses.
  - Default mode: o_frame_start pulses every 663168 clocks (1056 x 628).
  - o_line_start pulses every 1056 clocks.
- Default mode sync and blank placement:
  - o_horz_sync = 1 exactly for h = 840..967.
  - o_vert_sync = 1 exactly for v = 601..604.
  - o_horz_blank rises at h = 800; o_vert_blank rises at v = 600.
- Small mode (H 8/1/2/1, V 4/1/1/1, H_SYNC_POL = 0, FRAME_CNT_W = 2):
  - o_horz_sync = 0 only for h = 9..10.
  - Frame every 84 clocks.
  - o_frame_count sequence 0,1,2,3,0.
- i_pix_en asserted every 4th clock -> each coordinate held 4 clocks; start pulses stay 1 clock wide; frame period 4x.
- Assert i_reset_n = 0 mid-line at (123,45) -> all outputs reach reset values without a clock edge; after release, restart at (0,0) with o_frame_count = 0.
- With VGA_TIMING_LINE_IRQ_EN and i_irq_line = 10:
  - o_line_irq pulses once per frame, at the edge loading (800,10).
  - With i_irq_line = 700, no pulse.
